fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter:
// FSM state encoding and default geometry constants.
package fifo_arb_pkg;

  localparam int DATA_W       = 8;
  localparam int CNT_W        = 7;
  localparam int FIFO_DEPTH   = 64;
  localparam int AF_LEVEL_DEF = 62;

  // Arbiter control state; STALL is the registered backpressure state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
// A lone requester always wins; on a tie the requester that did not win
// the previous transfer (last_gnt names the previous winner) is chosen.
// block forces both acks low.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic block,
  output logic ack0,
  output logic ack1
);

  import fifo_arb_pkg::*;

  // Grant selection: at most one ack is ever raised.
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (!block) begin
      if (req0 && req1) begin
        ack0 = last_gnt;
        ack1 = !last_gnt;
      end else begin
        ack0 = req0;
        ack1 = req1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter in front of a FIFO.
// Handshake: reqN is a valid that stays up with dataN until acked; ackN is a
// combinational ready. A transfer happens at a rising edge where reqN && ackN,
// and the FIFO sees wr_en/buf_in for it exactly one cycle later.
// Backpressure (buf_full or occupancy >= AF_LEVEL) blocks acks immediately and
// moves the FSM to STALL; leaving STALL costs one cycle with acks still low.
// AF_LEVEL must lie in 1..62 so the single write in flight cannot overflow.
// Optional feature: define FIFO_ARB_STATS_EN to add the 16-bit saturating
// per-requester transfer counters gcnt0/gcnt1.
module fifo_wr_arbiter #(
  parameter int DATA_W   = fifo_arb_pkg::DATA_W,
  parameter int CNT_W    = fifo_arb_pkg::CNT_W,
  parameter int AF_LEVEL = fifo_arb_pkg::AF_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  input  logic              buf_full,
  input  logic [CNT_W-1:0]  fifo_counter,
  output logic              wr_en,
  output logic [DATA_W-1:0] buf_in,
  output logic              stall,
  output logic [1:0]        dbg_state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
`endif
);

  import fifo_arb_pkg::*;

  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_LEVEL);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_gnt;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_buf_in;

  logic w_stall_c;
  logic w_block;
  logic w_ack0;
  logic w_ack1;
  logic w_xfer0;
  logic w_xfer1;
  logic w_xfer;

  // Backpressure condition and grant blocking (reset also blocks acks).
  always_comb begin
    w_stall_c = buf_full || (fifo_counter >= AF_LVL);
    w_block   = !rst || w_stall_c || (r_state == STALL);
  end

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (r_last_gnt),
    .block    (w_block),
    .ack0     (w_ack0),
    .ack1     (w_ack1)
  );

  // Transfer qualification: a dropped req under ack is simply no transfer.
  always_comb begin
    w_xfer0 = req0 && w_ack0;
    w_xfer1 = req1 && w_ack1;
    w_xfer  = w_xfer0 || w_xfer1;
  end

  // Next-state logic; backpressure overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stall_c) begin
      w_state_nxt = STALL;
    end else begin
      case (r_state)
        IDLE:    if (w_xfer)  w_state_nxt = ACTIVE;
        ACTIVE:  if (!w_xfer) w_state_nxt = IDLE;
        STALL:   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Write strobe, write data and round-robin pointer; all move only on a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_en    <= 1'b0;
      r_buf_in   <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer0) begin
        r_buf_in   <= data0;
        r_last_gnt <= 1'b0;
      end else if (w_xfer1) begin
        r_buf_in   <= data1;
        r_last_gnt <= 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;

  // Per-requester transfer counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_xfer0 && (r_gcnt0 != 16'hFFFF)) r_gcnt0 <= r_gcnt0 + 16'd1;
      if (w_xfer1 && (r_gcnt1 != 16'hFFFF)) r_gcnt1 <= r_gcnt1 + 16'd1;
    end
  end

  assign gcnt0 = r_gcnt0;
  assign gcnt1 = r_gcnt1;
`endif

  assign ack0      = w_ack0;
  assign ack1      = w_ack1;
  assign wr_en     = r_wr_en;
  assign buf_in    = r_buf_in;
  assign stall     = (r_state == STALL);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// randomized traffic, checked against a rule-level reference model.
// Define FIFO_ARB_STATS_EN to also exercise the transfer counters.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int CW = 7;
  localparam int AF = 62;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          buf_full = 1'b0;
  logic [CW-1:0] fifo_counter = '0;
  logic          ack0, ack1, wr_en, stall;
  logic [DW-1:0] buf_in;
  logic [1:0]    dbg_state;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]   gcnt0, gcnt1;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_W(DW), .CNT_W(CW), .AF_LEVEL(AF)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .data0        (data0),
    .data1        (data1),
    .ack0         (ack0),
    .ack1         (ack1),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter),
    .wr_en        (wr_en),
    .buf_in       (buf_in),
    .stall        (stall),
    .dbg_state    (dbg_state)
`ifdef FIFO_ARB_STATS_EN
    ,
    .gcnt0        (gcnt0),
    .gcnt1        (gcnt1)
`endif
  );

  // ---------------- reference model state ----------------
  // Model view: acks are blocked in a cycle if reset is asserted, the FIFO is
  // (almost) full now, or it was (almost) full at the previous clock edge.
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            mon_en = 0;
  bit            exp_wr = 0;
  bit            exp_stall = 0;
  logic [DW-1:0] exp_hold = '0;
  bit            prev_full = 0;  // backpressure seen at previous edge
  int            prev_winner = 1;
  bit            e_ack0, e_ack1;
  int            m_g0 = 0, m_g1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit near_full();
    return buf_full || (int'(fifo_counter) >= AF);
  endfunction

  // Who the arbitration rules say should be acked with the current inputs.
  task automatic model_acks();
    int winner;
    winner = -1;
    if (rst && !near_full() && !prev_full) begin
      if (req0 && req1)  winner = (prev_winner == 0) ? 1 : 0;
      else if (req0)     winner = 0;
      else if (req1)     winner = 1;
    end
    e_ack0 = (winner == 0);
    e_ack1 = (winner == 1);
  endtask

  // Advance the model at a rising edge using the inputs the DUT just sampled.
  task automatic model_edge();
    if (!rst) begin
      exp_wr      = 0;
      exp_stall   = 0;
      exp_hold    = '0;
      prev_full   = 0;
      prev_winner = 1;
      m_g0        = 0;
      m_g1        = 0;
    end else begin
      exp_wr = e_ack0 || e_ack1;
      if (e_ack0) begin
        exp_q.push_back(data0);
        prev_winner = 0;
        m_g0++;
      end else if (e_ack1) begin
        exp_q.push_back(data1);
        prev_winner = 1;
        m_g1++;
      end
      exp_stall = near_full();
      prev_full = exp_stall;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r_n, input logic q0, input logic q1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic full, input logic [CW-1:0] cnt);
    @(negedge clk);
    rst = r_n; req0 = q0; req1 = q1; data0 = d0; data1 = d1;
    buf_full = full; fifo_counter = cnt;
    #1;
    model_acks();
    check("ack0", ack0, e_ack0);
    check("ack1", ack1, e_ack1);
    @(posedge clk);
    model_edge();
    mon_en = 1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("stall", stall, exp_stall);
      check("dbg_state_stall", (dbg_state == 2'(fifo_arb_pkg::STALL)), exp_stall);
      check("wr_en", wr_en, exp_wr);
      if (exp_wr) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd0, 32'd1);
        end else begin
          logic [DW-1:0] d;
          d = exp_q.pop_front();
          check("buf_in", buf_in, d);
          exp_hold = d;
        end
      end else begin
        check("buf_in_hold", buf_in, exp_hold);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles with both requesters active.
    step(0, 1, 1, 8'd5, 8'd6, 0, 7'd0);
    step(0, 1, 1, 8'd5, 8'd6, 0, 7'd0);

    // Single requester 0, new data every cycle.
    step(1, 1, 0, 8'd18, 8'd0, 0, 7'd0);
    step(1, 1, 0, 8'd9,  8'd0, 0, 7'd0);
    step(1, 1, 0, 8'd20, 8'd0, 0, 7'd0);
    step(1, 0, 0, 8'd0,  8'd0, 0, 7'd0);

    // Contention from a fresh reset: requester 0 wins the first tie.
    step(0, 0, 0, 8'd0, 8'd0, 0, 7'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 8'd40, 8'd64, 0, 7'd0);
    step(1, 0, 0, 8'd0, 8'd0, 0, 7'd0);

    // Almost-full threshold with requester 1.
    step(1, 0, 1, 8'd0, 8'd71, 0, 7'd61);
    step(1, 0, 1, 8'd0, 8'd72, 0, 7'd62);
    step(1, 0, 1, 8'd0, 8'd72, 0, 7'd62);
    step(1, 0, 1, 8'd0, 8'd72, 0, 7'd61);
    step(1, 0, 1, 8'd0, 8'd73, 0, 7'd61);
    step(1, 0, 1, 8'd0, 8'd74, 0, 7'd61);

    // Full flag at low occupancy, with a write in flight when it rises.
    step(1, 1, 0, 8'd90, 8'd0, 0, 7'd10);
    step(1, 1, 0, 8'd91, 8'd0, 1, 7'd10);
    step(1, 1, 0, 8'd91, 8'd0, 1, 7'd10);
    step(1, 1, 0, 8'd91, 8'd0, 0, 7'd10);
    step(1, 1, 0, 8'd92, 8'd0, 0, 7'd10);
    // Reset in the middle of a stream cancels the write registered at that edge.
    step(1, 1, 0, 8'd93, 8'd0, 0, 7'd10);
    step(0, 1, 0, 8'd94, 8'd0, 0, 7'd10);
    step(1, 0, 0, 8'd0,  8'd0, 0, 7'd10);

    // Counter scenario: 5 transfers from requester 0, 3 from requester 1.
    step(0, 0, 0, 8'd0, 8'd0, 0, 7'd0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 8'(100 + i), 8'd0, 0, 7'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'd0, 8'(200 + i), 0, 7'd0);
    step(1, 0, 0, 8'd0, 8'd0, 0, 7'd0);
`ifdef FIFO_ARB_STATS_EN
    #1;
    check("gcnt0_directed", gcnt0, 32'd5);
    check("gcnt1_directed", gcnt1, 32'd3);
`endif

    // Randomized traffic, including dropped requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic          r_n, q0, q1, full;
      logic [CW-1:0] cnt;
      r_n  = ($urandom_range(0, 59) != 0);
      q0   = ($urandom_range(0, 3) != 0);
      q1   = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) cnt = 7'($urandom_range(58, 63));
      else                           cnt = 7'($urandom_range(0, 57));
      step(r_n, q0, q1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), full, cnt);
    end

    // Drain and final checks.
    step(1, 0, 0, 8'd0, 8'd0, 0, 7'd0);
    step(1, 0, 0, 8'd0, 8'd0, 0, 7'd0);
`ifdef FIFO_ARB_STATS_EN
    #1;
    check("gcnt0_final", gcnt0, (m_g0 > 65535) ? 32'hFFFF : 32'(m_g0));
    check("gcnt1_final", gcnt1, (m_g1 > 65535) ? 32'hFFFF : 32'(m_g1));
`endif
    @(negedge clk);
    #2;
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
